// File: rtl/mod_pipe_reg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mod_pipe_reg
// Purpose  : Elastic DEPTH-stage {Tag,Data} pipeline register with valid/ready
//            handshake, bubble collapsing, synchronous flush and inverted copy.
//            Optional occupancy counter port o_occ when PIPE_OCC_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mod_pipe_reg #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 3
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_flush,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic [TAG_W+DATA_W-1:0]         i_D,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [TAG_W+DATA_W-1:0]         o_Q,
`ifdef PIPE_OCC_EN
  output logic [$clog2(DEPTH+1)-1:0]      o_occ,
`endif
  output logic [TAG_W+DATA_W-1:0]         o_nQ
);

  localparam int c_W = TAG_W + DATA_W;

  logic [DEPTH-1:0] w_v;
  logic [c_W-1:0]   w_d [DEPTH];
  logic [DEPTH-1:0] w_rdy;
  logic             w_carry;

  // A stage can load when it is empty or its content moves on this edge.
  always_comb begin
    w_carry = i_ready;
    w_rdy   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_carry  = ~w_v[k] | w_carry;
      w_rdy[k] = w_carry;
    end
  end

  assign o_ready = w_rdy[0] & ~i_flush;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic           r_v;
    logic [c_W-1:0] r_d;
    logic           w_src_v;
    logic [c_W-1:0] w_src_d;

    if (k == 0) begin : g_head
      // Empty slots always carry zero data so o_Q reads 0 while invalid.
      assign w_src_v = i_valid;
      assign w_src_d = i_valid ? i_D : '0;
    end else begin : g_body
      assign w_src_v = w_v[k-1];
      assign w_src_d = w_d[k-1];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_v <= 1'b0;
        r_d <= '0;
      end else if (i_flush) begin
        r_v <= 1'b0;
        r_d <= '0;
      end else if (w_rdy[k]) begin
        r_v <= w_src_v;
        r_d <= w_src_d;
      end
    end

    assign w_v[k] = r_v;
    assign w_d[k] = r_d;
  end

  assign o_valid = w_v[DEPTH-1];
  assign o_Q     = w_d[DEPTH-1];
  assign o_nQ    = ~w_d[DEPTH-1];

`ifdef PIPE_OCC_EN
  localparam int c_OCC_W = $clog2(DEPTH + 1);

  logic               w_in;
  logic               w_out;
  logic [c_OCC_W-1:0] r_occ;

  assign w_in  = i_valid & o_ready;
  assign w_out = w_v[DEPTH-1] & i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_occ <= '0;
    end else if (i_flush) begin
      r_occ <= '0;
    end else if (w_in && !w_out) begin
      r_occ <= r_occ + c_OCC_W'(1);
    end else if (!w_in && w_out) begin
      r_occ <= r_occ - c_OCC_W'(1);
    end
  end

  assign o_occ = r_occ;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mod_pipe_reg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mod_pipe_reg
// Purpose  : Scoreboard bench for mod_pipe_reg (DEPTH=3 12-bit and DEPTH=1 2-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstA_n, flA, ivA, irA, orA, ovA;
  logic [11:0] dA, qA_o, nqA;
  logic        rstB_n, flB, ivB, irB, orB, ovB;
  logic [1:0]  dB, qB_o, nqB;
`ifdef PIPE_OCC_EN
  logic [1:0]  occA;
  logic [0:0]  occB;
`endif

  mod_pipe_reg #(.TAG_W(4), .DATA_W(8), .DEPTH(3)) u_a (
    .i_clk(clk), .i_rst_n(rstA_n), .i_flush(flA), .i_valid(ivA), .o_ready(orA),
    .i_D(dA), .o_valid(ovA), .i_ready(irA), .o_Q(qA_o),
`ifdef PIPE_OCC_EN
    .o_occ(occA),
`endif
    .o_nQ(nqA));

  mod_pipe_reg #(.TAG_W(1), .DATA_W(1), .DEPTH(1)) u_b (
    .i_clk(clk), .i_rst_n(rstB_n), .i_flush(flB), .i_valid(ivB), .o_ready(orB),
    .i_D(dB), .o_valid(ovB), .i_ready(irB), .o_Q(qB_o),
`ifdef PIPE_OCC_EN
    .o_occ(occB),
`endif
    .o_nQ(nqB));

  logic [11:0] sbA[$];
  logic [1:0]  sbB[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for DUT A: pops the scoreboard on every output transfer.
  initial begin : mon_a
    logic [11:0] exp, inv, prev_q;
    logic        prev_stall;
    prev_stall = 1'b0;
    prev_q     = '0;
    forever begin
      @(negedge clk);
      if (rstA_n) begin
        inv = ~qA_o;
        check("A_nQ", nqA, inv);
        if (!ovA) check("A_Q_idle", qA_o, 0);
        if (prev_stall && ovA) check("A_stall_hold", qA_o, prev_q);
        if (ovA && irA) begin
          if (sbA.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL A_unexpected: got %0h expected none", qA_o);
          end else begin
            exp = sbA.pop_front();
            check("A_out", qA_o, exp);
          end
        end
        prev_stall = ovA & ~irA;
        prev_q     = qA_o;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin : mon_b
    logic [1:0] exp, inv, prev_q;
    logic       prev_stall;
    prev_stall = 1'b0;
    prev_q     = '0;
    forever begin
      @(negedge clk);
      if (rstB_n) begin
        inv = ~qB_o;
        check("B_nQ", nqB, inv);
        if (!ovB) check("B_Q_idle", qB_o, 0);
        if (prev_stall && ovB) check("B_stall_hold", qB_o, prev_q);
        if (ovB && irB) begin
          if (sbB.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL B_unexpected: got %0h expected none", qB_o);
          end else begin
            exp = sbB.pop_front();
            check("B_out", qB_o, exp);
          end
        end
        prev_stall = ovB & ~irB;
        prev_q     = qB_o;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic cycA(input logic v, input logic [11:0] d, input logic r, input logic f,
                      output logic acc, output logic ov);
    @(posedge clk); #1;
    ivA = v; dA = d; irA = r; flA = f;
    @(negedge clk);
    acc = v & orA;
    ov  = ovA;
    if (acc) sbA.push_back(d);
  endtask

  task automatic cycB(input logic v, input logic [1:0] d, input logic r, output logic acc);
    @(posedge clk); #1;
    ivB = v; dB = d; irB = r; flB = 1'b0;
    @(negedge clk);
    acc = v & orB;
    if (acc) sbB.push_back(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic        acc, ov, got;
    logic [11:0] bp [4];
    rstA_n = 1'b0; flA = 1'b0; ivA = 1'b1; dA = 12'h0A5; irA = 1'b1;
    rstB_n = 1'b0; flB = 1'b0; ivB = 1'b0; dB = 2'b00;  irB = 1'b0;

    // Reset with input valid held high
    repeat (2) @(negedge clk);
    check("rst_valid", ovA, 0);
    check("rst_Q", qA_o, 12'h000);
    check("rst_nQ", nqA, 12'hFFF);
`ifdef PIPE_OCC_EN
    check("rst_occ", occA, 0);
`endif
    #2 rstA_n = 1'b1;
    #1 check("rst_ready", orA, 1);
    ivA = 1'b0;

    // Streaming tags 1..8, data 0x10..0x17
    for (int i = 0; i < 8; i++) begin
      cycA(1'b1, {4'(i + 1), 8'(8'h10 + i)}, 1'b1, 1'b0, acc, ov);
      check("stream_acc", acc, 1);
      if (i == 1 || i == 2) check("stream_latency", ov, 0);
      if (i >= 3) check("stream_nogap", ov, 1);
    end
    for (int i = 0; i < 3; i++) begin
      cycA(1'b0, 12'h000, 1'b1, 1'b0, acc, ov);
      check("stream_tail", ov, 1);
    end
    cycA(1'b0, 12'h000, 1'b1, 1'b0, acc, ov);
    check("stream_empty", ov, 0);
    check("stream_sb_empty", sbA.size(), 0);

    // Backpressure
    for (int i = 0; i < 4; i++) bp[i] = {4'(4'h9 + i), 8'(8'h20 + i)};
    for (int i = 0; i < 4; i++) begin
      cycA(1'b1, bp[i], 1'b0, 1'b0, acc, ov);
      check("bp_acc", acc, (i < 3) ? 1 : 0);
    end
    check("bp_head", qA_o, bp[0]);
    for (int i = 0; i < 2; i++) begin
      cycA(1'b1, bp[3], 1'b0, 1'b0, acc, ov);
      check("bp_full", acc, 0);
      check("bp_hold", qA_o, bp[0]);
    end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycA(1'b1, bp[3], 1'b1, 1'b0, acc, ov);
      got = acc;
    end
    check("bp_accept4", got, 1);
    for (int i = 0; i < 20 && sbA.size() != 0; i++) cycA(1'b0, 12'h0, 1'b1, 1'b0, acc, ov);
    check("bp_drained", sbA.size(), 0);

    // Bubble collapse under a stalled output
    cycA(1'b1, 12'h3C1, 1'b0, 1'b0, acc, ov);
    check("bub_accX", acc, 1);
    cycA(1'b0, 12'h000, 1'b0, 1'b0, acc, ov);
    cycA(1'b0, 12'h000, 1'b0, 1'b0, acc, ov);
    cycA(1'b1, 12'h4D2, 1'b0, 1'b0, acc, ov);
    check("bub_accY", acc, 1);
    cycA(1'b0, 12'h000, 1'b0, 1'b0, acc, ov);
    cycA(1'b0, 12'h000, 1'b0, 1'b0, acc, ov);
    check("bub_headX", qA_o, 12'h3C1);
`ifdef PIPE_OCC_EN
    check("bub_occ", occA, 2);
`endif
    cycA(1'b1, 12'h5E3, 1'b0, 1'b0, acc, ov);
    check("bub_accZ", acc, 1);
    cycA(1'b1, 12'h6F4, 1'b0, 1'b0, acc, ov);
    check("bub_full", acc, 0);
    for (int i = 0; i < 20 && sbA.size() != 0; i++) cycA(1'b0, 12'h0, 1'b1, 1'b0, acc, ov);
    check("bub_drained", sbA.size(), 0);

    // Flush with three words in flight and an input offered
    for (int i = 0; i < 3; i++) begin
      cycA(1'b1, {4'(4'hD + i), 8'(8'h70 + i)}, 1'b0, 1'b0, acc, ov);
      check("fl_fill", acc, 1);
    end
    cycA(1'b1, 12'hE99, 1'b0, 1'b1, acc, ov);
    check("fl_ready", orA, 0);
    sbA.delete();
    cycA(1'b0, 12'h000, 1'b1, 1'b0, acc, ov);
    check("fl_valid", ov, 0);
    check("fl_Q", qA_o, 0);
`ifdef PIPE_OCC_EN
    check("fl_occ", occA, 0);
`endif
    for (int i = 0; i < 4; i++) begin
      cycA(1'b0, 12'h000, 1'b1, 1'b0, acc, ov);
      check("fl_no_emit", ov, 0);
    end

    // DEPTH=1 with random backpressure and a mid-stream reset
    @(negedge clk); #2 rstB_n = 1'b1;
    for (int i = 0; i < 40; i++)
      cycB(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), acc);
    cycB(1'b1, 2'b10, 1'b0, acc);
    cycB(1'b0, 2'b00, 1'b0, acc);
    check("B_pre_rst_valid", ovB, 1);
    #2 rstB_n = 1'b0;
    #1;
    check("B_rst_valid", ovB, 0);
    check("B_rst_Q", qB_o, 0);
    check("B_rst_nQ", nqB, 2'b11);
    sbB.delete();
    ivB = 1'b0;
    @(negedge clk); #2 rstB_n = 1'b1;
    for (int i = 0; i < 60; i++)
      cycB(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), acc);
    for (int i = 0; i < 10 && sbB.size() != 0; i++) cycB(1'b0, 2'b00, 1'b1, acc);
    check("B_drained", sbB.size(), 0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
